// File: rtl/bool_sweep_pkg.sv
// bool_sweep_pkg: shared sweep-state encoding and the default expected truth table.
package bool_sweep_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} sweep_state_t;
    localparam logic [7:0] DEFAULT_TT = 8'hE3;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: counts SETTLE_CYCLES clocks while clr is low; tick marks the last one.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(SETTLE_CYCLES + 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (clr || tick) ? '0 : r_cnt + 1'b1;
    end
    assign tick = !clr && (r_cnt == W'(SETTLE_CYCLES - 1));
endmodule

// File: rtl/bool_fn_sweeper.sv
// bool_fn_sweeper: sweeps every input vector of a Boolean function, records and checks its truth table.
// Define SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module bool_fn_sweeper
    import bool_sweep_pkg::*;
#(
    parameter int                 N_IN          = 3,
    parameter int                 SETTLE_CYCLES = 2,
    parameter logic [2**N_IN-1:0] EXPECTED_TT   = DEFAULT_TT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec_o,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   tt_o,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      first_fail
);
    sweep_state_t        r_state, w_next;
    logic [N_IN-1:0]     r_vec, r_ff;
    logic [2**N_IN-1:0]  r_tt;
    logic [N_IN:0]       r_err;
    logic                r_pass;
    logic                w_tick, w_mismatch, w_stop;

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (r_state != SETTLE),
        .tick (w_tick)
    );

    assign w_mismatch = f_in != EXPECTED_TT[r_vec];
`ifdef SWEEP_STOP_ON_FAIL_EN
    assign w_stop = (r_vec == '1) || w_mismatch;
`else
    assign w_stop = r_vec == '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? SETTLE : IDLE;
            SETTLE:  w_next = w_tick ? SAMPLE : SETTLE;
            SAMPLE:  w_next = w_stop ? DONE : SETTLE;
            default: w_next = IDLE;
        endcase
        if (abort) w_next = IDLE;
    end

    // abort wins over everything; partial results are kept for inspection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec  <= '0;
            r_tt   <= '0;
            r_err  <= '0;
            r_ff   <= '0;
            r_pass <= 1'b0;
        end else if (abort) begin
            r_vec <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_vec  <= '0;
                    r_tt   <= '0;
                    r_err  <= '0;
                    r_ff   <= '0;
                    r_pass <= 1'b0;
                end
                SAMPLE: begin
                    r_tt[r_vec] <= f_in;
                    if (w_mismatch) begin
                        r_err <= r_err + 1'b1;
                        if (r_err == '0) r_ff <= r_vec;
                    end
                    if (!w_stop) r_vec <= r_vec + 1'b1;
                end
                DONE: begin
                    r_pass <= r_err == '0;
                    r_vec  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign vec_o      = r_vec;
    assign busy       = r_state != IDLE;
    assign done       = r_state == DONE;
    assign pass       = r_pass;
    assign tt_o       = r_tt;
    assign err_cnt    = r_err;
    assign first_fail = r_ff;
endmodule
